// File: rtl/video_fetch_sched_pkg.sv
// Shared definitions for the video fetch scheduler: bandwidth codes, FSM states,
// pipe tag layout and the code-to-count decoders.
package video_fetch_sched_pkg;

  localparam logic [1:0] BW2 = 2'b00;
  localparam logic [1:0] BW4 = 2'b01;
  localparam logic [1:0] BW8 = 2'b11;

  localparam logic [2:0] BU1 = 3'b001;
  localparam logic [2:0] BU2 = 3'b010;
  localparam logic [2:0] BU4 = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_DRAIN = 2'b10
  } fetch_state_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [1:0] bsl;
  } fetch_tag_t;

  // Window length minus one, used as a slot mask; code 10 also means 8 slots.
  function automatic logic [2:0] win_mask(input logic [1:0] code);
    case (code)
      BW2:     return 3'd1;
      BW4:     return 3'd3;
      BW8:     return 3'd7;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] need_count(input logic [2:0] code);
    case (code)
      BU1:     return 3'd1;
      BU2:     return 3'd2;
      BU4:     return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/video_fetch_sched_pipe.sv
// DRAM read-latency tag pipe: carries {sel,bsl} plus a valid bit from the
// accepting clk to the clk on which the read data is on the bus.
module video_fetch_pipe
  import video_fetch_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  fetch_tag_t push_tag,
  output logic       exit_valid,
  output fetch_tag_t exit_tag,
  output logic       any_busy
);

  logic [DEPTH-1:0] vld_q;
  fetch_tag_t       tag_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      vld_q[0] <= push;
      tag_q[0] <= push_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign exit_valid = vld_q[DEPTH-1];
  assign exit_tag   = tag_q[DEPTH-1];

  // Busy covers only the stages that have not yet reached the data clk.
  always_comb begin
    any_busy = 1'b0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) any_busy = any_busy | vld_q[i];
  end

endmodule

// File: rtl/video_fetch_sched.sv
// Video fetch scheduler: paces DRAM read requests per slot window and packs the
// returned 16-bit words into the 32-bit word handed to the renderer.
module video_fetch_sched #(
  parameter int unsigned DRAM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c3,
  input  logic        line_start_s,
  input  logic        video_go,
  input  logic [4:0]  video_bw,
  input  logic [20:0] video_addr,
  input  logic [3:0]  fetch_sel,
  input  logic [1:0]  fetch_bsl,
  input  logic        fetch_stb,
  input  logic        dram_ack,
  input  logic [15:0] dram_rdata,
  output logic        dram_req,
  output logic [20:0] dram_addr,
  output logic        video_next,
  output logic [31:0] fetch_data,
  output logic        fetch_late
);
  import video_fetch_sched_pkg::*;

  fetch_state_t state;
  logic [2:0]   slot;
  logic [2:0]   used;
  logic [2:0]   mask;
  logic [2:0]   need;
  logic         wrap;
  logic         accept;
  logic         exit_valid;
  logic         any_busy;
  logic         pipe_empty;
  fetch_tag_t   push_tag;
  fetch_tag_t   exit_tag;
  logic [31:0]  asm_word;
  logic [31:0]  merged;

  assign mask       = win_mask(video_bw[4:3]);
  assign need       = need_count(video_bw[2:0]);
  assign wrap       = c3 && ((slot & mask) == mask);
  assign dram_req   = (state == ST_ARMED) && video_go && (used < need) && !line_start_s;
  assign accept     = dram_ack && dram_req;
  assign video_next = accept;
  assign dram_addr  = video_addr;
  assign push_tag   = '{sel: fetch_sel, bsl: fetch_bsl};
  assign pipe_empty = !any_busy && !exit_valid;

  video_fetch_pipe #(
    .DEPTH (DRAM_LAT)
  ) u_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept),
    .push_tag   (push_tag),
    .exit_valid (exit_valid),
    .exit_tag   (exit_tag),
    .any_busy   (any_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (video_go) state <= ST_ARMED;
        ST_ARMED: if (!video_go) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (video_go)        state <= ST_ARMED;
          else if (pipe_empty) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // An ack landing on the wrap clk is charged to the window that starts there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
      used <= '0;
    end else begin
      if (line_start_s)          slot <= '0;
      else if (c3 && video_go)   slot <= slot + 3'd1;
      if (wrap)                  used <= accept ? 3'd1 : 3'd0;
      else if (accept)           used <= used + 3'd1;
    end
  end

  always_comb begin
    merged = asm_word;
    if (exit_valid) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (exit_tag.sel[i]) begin
          merged[8*i +: 8] = ((i % 2 == 1) ? exit_tag.bsl[1] : exit_tag.bsl[0])
                             ? dram_rdata[15:8] : dram_rdata[7:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_word   <= '0;
      fetch_data <= '0;
      fetch_late <= 1'b0;
    end else begin
      if (exit_valid) asm_word <= merged;
      if (fetch_stb) begin
        fetch_data <= merged;
        if (any_busy) fetch_late <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_fetch_sched.sv
// Self-checking bench for video_fetch_sched against a cycle-indexed reference
// model built from request/landing timestamps.
module tb_video_fetch_sched;

  localparam int LAT     = 2;
  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_DRAIN = 2;

  logic        clk;
  logic        rst_n;
  logic        c3;
  logic        line_start_s;
  logic        video_go;
  logic [4:0]  video_bw;
  logic [20:0] video_addr;
  logic [3:0]  fetch_sel;
  logic [1:0]  fetch_bsl;
  logic        fetch_stb;
  logic        dram_ack;
  logic [15:0] dram_rdata;
  logic        dram_req;
  logic [20:0] dram_addr;
  logic        video_next;
  logic [31:0] fetch_data;
  logic        fetch_late;

  int checks   = 0;
  int failures = 0;

  video_fetch_sched #(
    .DRAM_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .c3           (c3),
    .line_start_s (line_start_s),
    .video_go     (video_go),
    .video_bw     (video_bw),
    .video_addr   (video_addr),
    .fetch_sel    (fetch_sel),
    .fetch_bsl    (fetch_bsl),
    .fetch_stb    (fetch_stb),
    .dram_ack     (dram_ack),
    .dram_rdata   (dram_rdata),
    .dram_req     (dram_req),
    .dram_addr    (dram_addr),
    .video_next   (video_next),
    .fetch_data   (fetch_data),
    .fetch_late   (fetch_late)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: reads are timestamped with the clk they land on.
  typedef struct {
    int         land;
    logic [3:0] sel;
    logic [1:0] bsl;
  } rd_t;

  rd_t         m_q[$];
  int          m_cyc   = 0;
  int          m_slot  = 0;
  int          m_used  = 0;
  int          m_phase = P_IDLE;
  logic [31:0] m_asm   = '0;
  logic [31:0] m_fd    = '0;
  logic        m_late  = 1'b0;

  function automatic int win_len(input logic [1:0] code);
    if (code == 2'b00) return 2;
    if (code == 2'b01) return 4;
    return 8;
  endfunction

  function automatic int need_n(input logic [2:0] code);
    if (code == 3'b010) return 2;
    if (code == 3'b100) return 4;
    return 1;
  endfunction

  function automatic logic exp_req();
    return (m_phase == P_ARMED) && video_go && (m_used < need_n(video_bw[2:0])) && !line_start_s;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_slot  = 0;
    m_used  = 0;
    m_phase = P_IDLE;
    m_asm   = '0;
    m_fd    = '0;
    m_late  = 1'b0;
  endtask

  task automatic model_edge();
    logic [31:0] nxt;
    logic        acc;
    logic        empty;
    logic        late;
    logic        hi;
    int          len;
    nxt   = m_asm;
    acc   = exp_req() && dram_ack;
    empty = (m_q.size() == 0);
    late  = 1'b0;
    foreach (m_q[i]) if (m_q[i].land > m_cyc) late = 1'b1;
    if (m_q.size() > 0 && m_q[0].land == m_cyc) begin
      for (int b = 0; b < 4; b++) begin
        if (m_q[0].sel[b]) begin
          hi = (b % 2 == 1) ? m_q[0].bsl[1] : m_q[0].bsl[0];
          nxt[8*b +: 8] = hi ? dram_rdata[15:8] : dram_rdata[7:0];
        end
      end
      void'(m_q.pop_front());
    end
    if (fetch_stb) begin
      m_fd = nxt;
      if (late) m_late = 1'b1;
    end
    m_asm = nxt;
    if (acc) m_q.push_back('{land: m_cyc + LAT, sel: fetch_sel, bsl: fetch_bsl});
    len = win_len(video_bw[4:3]);
    if (c3 && (m_slot % len) == len - 1) m_used = acc ? 1 : 0;
    else if (acc)                         m_used = m_used + 1;
    if (line_start_s)         m_slot = 0;
    else if (c3 && video_go)  m_slot = (m_slot + 1) % 8;
    case (m_phase)
      P_IDLE:  if (video_go) m_phase = P_ARMED;
      P_ARMED: if (!video_go) m_phase = P_DRAIN;
      default: begin
        if (video_go)   m_phase = P_ARMED;
        else if (empty) m_phase = P_IDLE;
      end
    endcase
    m_cyc = m_cyc + 1;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    c3           = 1'b0;
    line_start_s = 1'b0;
    dram_ack     = 1'b0;
    fetch_stb    = 1'b0;
    fetch_sel    = 4'($urandom);
    fetch_bsl    = 2'($urandom);
    dram_rdata   = 16'($urandom);
    video_addr   = 21'($urandom);
  endtask

  task automatic drain();
    video_go = 1'b0;
    repeat (6) begin
      drive_idle();
      step();
    end
  endtask

  // Obtains exactly one accepted request carrying the given tag.
  task automatic issue_read(input logic [3:0] s, input logic [1:0] b, output logic ok);
    ok       = 1'b0;
    video_bw = 5'b00_100;
    video_go = 1'b1;
    for (int i = 0; i < 24 && !ok; i++) begin
      drive_idle();
      #1;
      if (exp_req()) begin
        dram_ack  = 1'b1;
        fetch_sel = s;
        fetch_bsl = b;
        ok        = 1'b1;
      end else begin
        c3 = 1'b1;
      end
      step();
    end
    drive_idle();
  endtask

  task automatic read_land(input logic [3:0] s, input logic [1:0] b, input logic [15:0] data,
                           input logic stb_at_land, output logic ok);
    issue_read(s, b, ok);
    for (int i = 1; i < LAT; i++) begin
      drive_idle();
      step();
    end
    drive_idle();
    dram_rdata = data;
    fetch_stb  = stb_at_land;
    step();
    drive_idle();
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    video_go     = 1'b0;
    video_bw     = '0;
    drive_idle();
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++; if (dram_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", dram_req); end
    checks++; if (video_next !== 1'b0) begin failures++; $display("FAIL reset_next got=%b exp=0", video_next); end
    checks++; if (fetch_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", fetch_data); end
    checks++; if (fetch_late !== 1'b0) begin failures++; $display("FAIL reset_late got=%b exp=0", fetch_late); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zx();
    int nexts = 0;
    video_bw = 5'b11_001;
    video_go = 1'b1;
    drive_idle();
    line_start_s = 1'b1;
    step();
    for (int k = 0; k < 128; k++) begin
      drive_idle();
      dram_ack = 1'b1;
      c3       = (k % 4 == 3);
      #1;
      checks++; if (dram_req !== exp_req()) begin failures++; $display("FAIL zx_req k=%0d got=%b exp=%b", k, dram_req, exp_req()); end
      checks++; if (video_next !== exp_req()) begin failures++; $display("FAIL zx_next k=%0d got=%b exp=%b", k, video_next, exp_req()); end
      if (video_next === 1'b1) nexts++;
      step();
    end
    checks++; if (nexts !== 4) begin failures++; $display("FAIL zx_count got=%0d exp=4", nexts); end
    drain();
  endtask

  task automatic test_text();
    int   nexts    = 0;
    logic prev_req = 1'b0;
    video_bw = 5'b11_100;
    video_go = 1'b1;
    drive_idle();
    line_start_s = 1'b1;
    step();
    for (int k = 0; k < 96; k++) begin
      drive_idle();
      dram_ack = prev_req;
      c3       = (k % 4 == 3);
      #1;
      prev_req = exp_req();
      checks++; if (dram_req !== prev_req) begin failures++; $display("FAIL text_req k=%0d got=%b exp=%b", k, dram_req, prev_req); end
      checks++; if (video_next !== (prev_req && dram_ack)) begin failures++; $display("FAIL text_next k=%0d got=%b exp=%b", k, video_next, prev_req && dram_ack); end
      if (video_next === 1'b1) nexts++;
      step();
    end
    checks++; if (nexts !== 12) begin failures++; $display("FAIL text_count got=%0d exp=12", nexts); end
    drain();
  endtask

  task automatic test_lane_merge();
    logic ok;
    read_land(4'b0011, 2'b10, 16'hA1B2, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL lm_issue1 got=%b exp=1", ok); end
    fetch_stb = 1'b1;
    step();
    drive_idle();
    checks++; if (fetch_data[15:0] !== 16'hA1B2) begin failures++; $display("FAIL lm_word1 got=%h exp=a1b2", fetch_data[15:0]); end
    checks++; if (fetch_data !== m_fd) begin failures++; $display("FAIL lm_model1 got=%h exp=%h", fetch_data, m_fd); end
    read_land(4'b0001, 2'b11, 16'h77C3, 1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL lm_issue2 got=%b exp=1", ok); end
    fetch_stb = 1'b1;
    step();
    drive_idle();
    checks++; if (fetch_data[15:0] !== 16'hA177) begin failures++; $display("FAIL lm_word2 got=%h exp=a177", fetch_data[15:0]); end
    checks++; if (fetch_data !== m_fd) begin failures++; $display("FAIL lm_model2 got=%h exp=%h", fetch_data, m_fd); end
  endtask

  task automatic test_bypass();
    logic ok;
    read_land(4'b1111, 2'b01, 16'h5AC3, 1'b1, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL byp_issue got=%b exp=1", ok); end
    checks++; if (fetch_data !== 32'hC35AC35A) begin failures++; $display("FAIL byp_data got=%h exp=c35ac35a", fetch_data); end
    checks++; if (fetch_late !== 1'b0) begin failures++; $display("FAIL byp_late got=%b exp=0", fetch_late); end
  endtask

  task automatic test_late();
    logic ok;
    issue_read(4'($urandom), 2'($urandom), ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL late_issue got=%b exp=1", ok); end
    for (int i = 1; i < LAT - 1; i++) begin
      drive_idle();
      step();
    end
    drive_idle();
    fetch_stb = 1'b1;
    step();
    drive_idle();
    checks++; if (fetch_late !== 1'b1) begin failures++; $display("FAIL late_set got=%b exp=1", fetch_late); end
    repeat (8) begin
      drive_idle();
      step();
    end
    checks++; if (fetch_late !== 1'b1) begin failures++; $display("FAIL late_sticky got=%b exp=1", fetch_late); end
    checks++; if (m_late !== 1'b1) begin failures++; $display("FAIL late_model got=%b exp=1", m_late); end
  endtask

  task automatic test_reset_mid();
    logic ok;
    issue_read(4'b1111, 2'b11, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rmid_issue got=%b exp=1", ok); end
    #1;
    if (exp_req()) begin
      dram_ack  = 1'b1;
      fetch_sel = 4'b1111;
    end
    step();
    drive_idle();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    checks++; if (dram_req !== 1'b0) begin failures++; $display("FAIL rmid_req got=%b exp=0", dram_req); end
    checks++; if (video_next !== 1'b0) begin failures++; $display("FAIL rmid_next got=%b exp=0", video_next); end
    checks++; if (fetch_data !== 32'h0) begin failures++; $display("FAIL rmid_data got=%h exp=0", fetch_data); end
    checks++; if (fetch_late !== 1'b0) begin failures++; $display("FAIL rmid_late got=%b exp=0", fetch_late); end
    video_go = 1'b0;
    repeat (2) begin
      @(negedge clk);
      drive_idle();
      dram_rdata = 16'hFFFF;
    end
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      drive_idle();
      dram_rdata = 16'hFFFF;
      fetch_stb  = 1'b1;
      step();
      checks++; if (fetch_data !== 32'h0) begin failures++; $display("FAIL rmid_nowrite i=%0d got=%h exp=0", i, fetch_data); end
    end
    checks++; if (fetch_late !== 1'b0) begin failures++; $display("FAIL rmid_late_after got=%b exp=0", fetch_late); end
    drive_idle();
  endtask

  task automatic test_random();
    video_go = 1'b1;
    video_bw = 5'b11_010;
    for (int half = 0; half < 2; half++) begin
      for (int k = 0; k < 300; k++) begin
        if ($urandom % 30 == 0) video_go = ~video_go;
        if ($urandom % 50 == 0) video_bw = 5'($urandom);
        drive_idle();
        c3           = ($urandom % 3 == 0);
        line_start_s = ($urandom % 40 == 0);
        dram_ack     = 1'($urandom);
        fetch_stb    = ($urandom % 7 == 0);
        #1;
        checks++; if (dram_req !== exp_req()) begin failures++; $display("FAIL rnd_req k=%0d got=%b exp=%b", k, dram_req, exp_req()); end
        checks++; if (video_next !== (exp_req() && dram_ack)) begin failures++; $display("FAIL rnd_next k=%0d got=%b exp=%b", k, video_next, exp_req() && dram_ack); end
        checks++; if (dram_addr !== video_addr) begin failures++; $display("FAIL rnd_addr k=%0d got=%h exp=%h", k, dram_addr, video_addr); end
        step();
        checks++; if (fetch_data !== m_fd) begin failures++; $display("FAIL rnd_data k=%0d got=%h exp=%h", k, fetch_data, m_fd); end
        checks++; if (fetch_late !== m_late) begin failures++; $display("FAIL rnd_late k=%0d got=%b exp=%b", k, fetch_late, m_late); end
      end
      rst_n = 1'b0;
      m_reset();
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    video_go     = 1'b0;
    video_bw     = '0;
    c3           = 1'b0;
    line_start_s = 1'b0;
    dram_ack     = 1'b0;
    fetch_stb    = 1'b0;
    fetch_sel    = '0;
    fetch_bsl    = '0;
    dram_rdata   = '0;
    video_addr   = '0;
    test_reset();
    test_zx();
    test_text();
    test_lane_merge();
    test_bypass();
    test_late();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
